// File: rtl/keypad_fifo.sv
// Keypad receive FIFO with a two-register CPU bus window (DATA, STATUS/CTRL).
// Level irq is asserted while codes are pending.
module keypad_fifo #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  key_code,
  input  logic        key_valid,
  input  logic        bus_sel,
  input  logic        bus_rd,
  input  logic        bus_wr,
  input  logic        bus_addr,
  input  logic [7:0]  bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        irq
);

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [31:0]      rdata_q, rdata_d;

  logic empty, full;
  logic rd_req, wr_req, ctrl_wr, flush, clr_ovf;
  logic push_req, pop, push_ok, ovf_set;

  always_comb begin
    empty    = (cnt_q == '0);
    full     = (cnt_q == (PTR_W+1)'(DEPTH));
    rd_req   = bus_sel & bus_rd;
    // A write coinciding with a read is dropped
    wr_req   = bus_sel & bus_wr & ~bus_rd;
    ctrl_wr  = wr_req & bus_addr;
    flush    = ctrl_wr & bus_wdata[1];
    clr_ovf  = ctrl_wr & bus_wdata[0];
    push_req = key_valid & (key_code != '0);
    pop      = rd_req & ~bus_addr & ~empty;
    // A same-cycle pop frees the slot, so a push into a full FIFO still lands
    push_ok  = push_req & (~full | pop) & ~flush;
    ovf_set  = push_req & full & ~pop & ~flush;
  end

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (flush) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_ok) wp_d = wp_q + 1'b1;
      if (pop)     rp_d = rp_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_set)      ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_req) begin
      if (bus_addr) rdata_d = {16'b0, ovf_q, full, empty, 5'b0, 8'(cnt_q)};
      else          rdata_d = pop ? {24'b0, mem_q[rp_q]} : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is not reset; contents are meaningless until written
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wp_q] <= key_code;
  end

  assign bus_rdata = rdata_q;
  assign irq       = ~empty;

endmodule

// File: tb/tb_keypad_fifo.sv
// Directed bench for keypad_fifo: queue-based reference model checked every
// cycle, plus literal expectations from hand-worked scenarios.
module tb_keypad_fifo;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  key_code = '0;
  logic        key_valid = 1'b0;
  logic        bus_sel = 1'b0;
  logic        bus_rd = 1'b0;
  logic        bus_wr = 1'b0;
  logic        bus_addr = 1'b0;
  logic [7:0]  bus_wdata = '0;
  logic [31:0] bus_rdata;
  logic        irq;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Reference model state
  logic [7:0]  m_q [$];
  logic        m_ovf = 1'b0;
  logic [31:0] m_rdata = '0;

  keypad_fifo #(.DEPTH(DEPTH), .PTR_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .key_code(key_code), .key_valid(key_valid),
    .bus_sel(bus_sel), .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_status();
    int n = m_q.size();
    return {16'b0, m_ovf, n == DEPTH, n == 0, 5'b0, 8'(n)};
  endfunction

  task automatic model_step();
    bit rd, wr, popped, flush, clr, set;
    int n;
    rd = bus_sel && bus_rd;
    wr = bus_sel && bus_wr && !bus_rd;
    flush = wr && bus_addr && bus_wdata[1];
    clr = wr && bus_addr && bus_wdata[0];
    n = m_q.size();
    popped = 1'b0;
    set = 1'b0;
    if (rd) begin
      if (bus_addr) m_rdata = m_status();
      else if (n > 0) begin
        m_rdata = {24'b0, m_q[0]};
        popped = 1'b1;
      end else m_rdata = '0;
    end
    if (popped) void'(m_q.pop_front());
    if (flush) m_q.delete();
    else if (key_valid && key_code != 8'h00) begin
      if (n < DEPTH || popped) m_q.push_back(key_code);
      else set = 1'b1;
    end
    if (set) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  always @(posedge clk) begin
    if (rst_n) model_step();
    #1;
    if (chk_en) begin
      check("rdata", bus_rdata, m_rdata);
      check("irq", {31'b0, irq}, {31'b0, m_q.size() != 0});
    end
  end

  // Hold one cycle of inputs starting at a falling edge, then return to idle
  task automatic drive(input bit kv, input logic [7:0] kc, input bit sel, input bit rd,
                       input bit wr, input bit addr, input logic [7:0] wd);
    key_valid = kv; key_code = kc; bus_sel = sel; bus_rd = rd;
    bus_wr = wr; bus_addr = addr; bus_wdata = wd;
    @(negedge clk);
    key_valid = 0; key_code = '0; bus_sel = 0; bus_rd = 0;
    bus_wr = 0; bus_addr = 0; bus_wdata = '0;
  endtask

  task automatic push(input logic [7:0] c);      drive(1, c, 0, 0, 0, 0, 8'h00); endtask
  task automatic rd_data();                      drive(0, 8'h00, 1, 1, 0, 0, 8'h00); endtask
  task automatic rd_stat();                      drive(0, 8'h00, 1, 1, 0, 1, 8'h00); endtask
  task automatic wr_ctrl(input logic [7:0] v);   drive(0, 8'h00, 1, 0, 1, 1, v); endtask

  task automatic expect_stat(input string name, input logic [31:0] v);
    rd_stat();
    check(name, bus_rdata, v);
  endtask

  task automatic expect_pop(input string name, input logic [7:0] v);
    rd_data();
    check(name, bus_rdata, {24'b0, v});
  endtask

  initial begin
    logic [7:0] seq [8];
    #12;
    @(negedge clk);
    check("reset_rdata", bus_rdata, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Basic path
    expect_stat("stat_after_reset", 32'h2000);
    push(8'h31);
    check("irq_after_push", {31'b0, irq}, 32'h1);
    expect_stat("stat_one", 32'h0001);
    expect_pop("pop_31", 8'h31);
    expect_stat("stat_drained", 32'h2000);
    check("irq_drained", {31'b0, irq}, 32'h0);

    // Ordering and pointer wrap
    for (int i = 0; i < 8; i++) push(8'(8'h31 + i));
    for (int i = 0; i < 4; i++) expect_pop("wrap_first4", 8'(8'h31 + i));
    for (int i = 0; i < 4; i++) push(8'(8'h41 + i));
    seq = '{8'h35, 8'h36, 8'h37, 8'h38, 8'h41, 8'h42, 8'h43, 8'h44};
    for (int i = 0; i < 8; i++) expect_pop("wrap_seq", seq[i]);

    // Overflow
    for (int i = 0; i < 9; i++) push(8'(8'h30 + i));
    expect_stat("stat_ovf_full", 32'hC008);
    for (int i = 0; i < 8; i++) expect_pop("ovf_drain", 8'(8'h30 + i));
    expect_stat("stat_ovf_empty", 32'hA000);
    wr_ctrl(8'h01);
    expect_stat("stat_ovf_cleared", 32'h2000);

    // Push + pop while full
    for (int i = 0; i < 8; i++) push(8'(8'h50 + i));
    drive(1, 8'h44, 1, 1, 0, 0, 8'h00);
    check("full_pushpop_data", bus_rdata, 32'h50);
    expect_stat("stat_full_pushpop", 32'h4008);
    for (int i = 1; i < 8; i++) expect_pop("full_drain", 8'(8'h50 + i));
    expect_pop("full_last_44", 8'h44);

    // Empty read and zero code
    expect_pop("empty_read", 8'h00);
    expect_stat("stat_empty_read", 32'h2000);
    push(8'h00);
    check("zero_code_irq", {31'b0, irq}, 32'h0);
    expect_stat("stat_zero_code", 32'h2000);
    drive(1, 8'h61, 1, 1, 0, 0, 8'h00);
    check("empty_pushpop_data", bus_rdata, 32'h0);
    expect_stat("stat_empty_pushpop", 32'h0001);
    expect_pop("empty_pushpop_pop", 8'h61);

    // Read and write together: read wins, flush ignored
    for (int i = 0; i < 3; i++) push(8'(8'h70 + i));
    drive(0, 8'h00, 1, 1, 1, 1, 8'h02);
    check("rdwr_stat", bus_rdata, 32'h0003);
    // Flush races with push
    drive(1, 8'h42, 1, 0, 1, 1, 8'h02);
    expect_stat("stat_flush_push", 32'h2000);
    check("flush_irq", {31'b0, irq}, 32'h0);

    // Clear ovf vs new overflow, then flush vs overflow
    for (int i = 0; i < 9; i++) push(8'(8'h20 + i));
    drive(1, 8'h29, 1, 0, 1, 1, 8'h01);
    expect_stat("stat_clr_vs_set", 32'hC008);
    drive(1, 8'h2A, 1, 0, 1, 1, 8'h02);
    expect_stat("stat_flush_keeps_ovf", 32'hA000);
    wr_ctrl(8'h01);
    expect_stat("stat_final_clear", 32'h2000);

    // Asynchronous reset mid-operation
    for (int i = 0; i < 5; i++) push(8'(8'h80 + i));
    expect_pop("pre_reset_pop", 8'h80);
    #2;
    rst_n = 1'b0;
    m_q.delete();
    m_ovf = 1'b0;
    m_rdata = '0;
    #1;
    check("async_rst_rdata", bus_rdata, 32'h0);
    check("async_rst_irq", {31'b0, irq}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    push(8'h61);
    expect_stat("stat_post_reset", 32'h0001);
    expect_pop("post_reset_pop", 8'h61);

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
